// File: rtl/edge_event_monitor_pkg.sv
// Shared types and sizing helpers for the edge event monitor.
// The event record layout is fixed by the localparams below.
package edge_event_monitor_pkg;

  localparam int C_SIG_NB     = 5;
  localparam int C_TS_WIDTH   = 32;
  localparam int C_FIFO_DEPTH = 16;
  localparam int C_DROP_WIDTH = 8;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int C_CHAN_W     = clog2_min1(C_SIG_NB);
  localparam int C_FIFO_LVL_W = $clog2(C_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [C_CHAN_W-1:0]   chan;
    logic                  rise;
    logic [C_TS_WIDTH-1:0] tstamp;
  } evt_rec_t;

endpackage

// File: rtl/edge_event_monitor_evt_fifo.sv
// Synchronous FIFO of event records with a valid/ready read port.
// A push is accepted when not full, or when full and a pop happens in the same cycle.
module evt_fifo
  import edge_event_monitor_pkg::*;
#(
  parameter int  DEPTH = C_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  evt_rec_t         i_data,
  output logic             o_push_ack,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output evt_rec_t         o_data,
  output logic [LVL_W-1:0] o_level
);

  evt_rec_t         mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop;

  // NOTE: combinational blocks use blocking '=' and assign every output first,
  // so each path has a defined value and no latch is inferred.
  always_comb begin
    o_full     = (level_q == LVL_W'(DEPTH));
    o_valid    = (level_q != '0);
    pop        = o_valid & i_ready;
    o_push_ack = i_push & (~o_full | pop);
    wr_ptr_d   = wr_ptr_q + AW'(o_push_ack);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LVL_W'(o_push_ack) - LVL_W'(pop);
    o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
    o_level    = level_q;
  end

  // NOTE: sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; a slot is only read after it has been written,
  // and the head is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (o_push_ack) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/edge_event_monitor.sv
// Masked rising/falling edge monitor: one-cycle pulses plus timestamped records in a FIFO.
// Define EDGE_EVENT_MONITOR_SYNC_EN to add a 2-flop synchronizer on i_sig.
module edge_event_monitor
  import edge_event_monitor_pkg::*;
#(
  parameter int  SIG_NB     = C_SIG_NB,
  parameter int  TS_WIDTH   = C_TS_WIDTH,
  parameter int  FIFO_DEPTH = C_FIFO_DEPTH,
  parameter int  DROP_WIDTH = C_DROP_WIDTH,
  localparam int CHAN_W     = clog2_min1(SIG_NB),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [SIG_NB-1:0]     i_rise_mask,
  input  logic [SIG_NB-1:0]     i_fall_mask,
  input  logic [SIG_NB-1:0]     i_sig,
  output logic [SIG_NB-1:0]     o_evt_pulse,
  output logic                  o_evt_valid,
  input  logic                  i_evt_ready,
  output logic [CHAN_W-1:0]     o_evt_chan,
  output logic                  o_evt_rise,
  output logic [TS_WIDTH-1:0]   o_evt_tstamp,
  output logic [LVL_W-1:0]      o_fifo_level,
  output logic                  o_overflow,
  output logic [DROP_WIDTH-1:0] o_drop_cnt,
  input  logic                  i_clr_overflow
);

  localparam int SUM_W = DROP_WIDTH + 7;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [SIG_NB-1:0]     sig_in;
  logic [SIG_NB-1:0]     sig_q, sig_d;
  logic                  first_done_q, first_done_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [SIG_NB-1:0]     pulse_q, pulse_d;
  logic [SIG_NB-1:0]     pend_q, pend_d;
  logic [SIG_NB-1:0]     pend_rise_q, pend_rise_d;
  logic [TS_WIDTH-1:0]   pend_ts_q [SIG_NB];
  logic [TS_WIDTH-1:0]   pend_ts_d [SIG_NB];
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic                  det_en;
  logic [SIG_NB-1:0]     det_rise, det_fall, det, drop, grant;
  logic                  arb_found, push_req, push_ack;
  logic                  fifo_full, head_valid;
  logic [LVL_W-1:0]      fifo_level;
  logic [SUM_W-1:0]      drop_n, drop_sum;
  evt_rec_t              wr_rec, head_rec;

`ifdef EDGE_EVENT_MONITOR_SYNC_EN
  logic [SIG_NB-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sig;
      sync2_q <= sync1_q;
    end
  end

  assign sig_in = sync2_q;
`else
  assign sig_in = i_sig;
`endif

  // The very first sample after reset only seeds the history register.
  assign det_en   = i_enable & first_done_q;
  assign det_rise = sig_in & ~sig_q & i_rise_mask & {SIG_NB{det_en}};
  assign det_fall = ~sig_in & sig_q & i_fall_mask & {SIG_NB{det_en}};
  assign det      = det_rise | det_fall;
  assign drop     = det & pend_q;

  // Fixed priority: lowest-index pending channel gets the single FIFO write slot.
  always_comb begin
    grant     = '0;
    arb_found = 1'b0;
    wr_rec    = '0;
    for (int i = 0; i < SIG_NB; i++) begin
      if (pend_q[i] && !arb_found) begin
        arb_found     = 1'b1;
        grant[i]      = 1'b1;
        wr_rec.chan   = C_CHAN_W'(i);
        wr_rec.rise   = pend_rise_q[i];
        wr_rec.tstamp = pend_ts_q[i];
      end
    end
    push_req = arb_found;
  end

  always_comb begin
    sig_d        = sig_in;
    first_done_d = 1'b1;
    ts_d         = ts_q + TS_WIDTH'(1);
    pulse_d      = det;
    pend_d       = (pend_q & ~(grant & {SIG_NB{push_ack}})) | (det & ~pend_q);
    pend_rise_d  = pend_rise_q;
    pend_ts_d    = pend_ts_q;
    drop_n       = '0;
    for (int i = 0; i < SIG_NB; i++) begin
      if (det[i] && !pend_q[i]) begin
        pend_rise_d[i] = det_rise[i];
        pend_ts_d[i]   = ts_q;
      end
      drop_n = drop_n + SUM_W'(drop[i]);
    end

    // A drop in the same cycle as a clear restarts the count from zero.
    drop_sum   = (i_clr_overflow ? '0 : SUM_W'(drop_cnt_q)) + drop_n;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (|drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
    end else if (i_clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q        <= '0;
      first_done_q <= 1'b0;
      ts_q         <= '0;
      pulse_q      <= '0;
      pend_q       <= '0;
      pend_rise_q  <= '0;
      for (int i = 0; i < SIG_NB; i++) pend_ts_q[i] <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      sig_q        <= sig_d;
      first_done_q <= first_done_d;
      ts_q         <= ts_d;
      pulse_q      <= pulse_d;
      pend_q       <= pend_d;
      pend_rise_q  <= pend_rise_d;
      pend_ts_q    <= pend_ts_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (push_req),
    .i_data     (wr_rec),
    .o_push_ack (push_ack),
    .o_full     (fifo_full),
    .o_valid    (head_valid),
    .i_ready    (i_evt_ready),
    .o_data     (head_rec),
    .o_level    (fifo_level)
  );

  assign o_evt_pulse  = pulse_q;
  assign o_evt_valid  = head_valid;
  assign o_evt_chan   = head_rec.chan;
  assign o_evt_rise   = head_rec.rise;
  assign o_evt_tstamp = head_rec.tstamp;
  assign o_fifo_level = fifo_level;
  assign o_overflow   = overflow_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Self-checking bench for edge_event_monitor: directed scenarios plus randomized
// stimulus, all compared each cycle against a queue-based transaction model.
module tb_edge_event_monitor;
  import edge_event_monitor_pkg::*;

  localparam int N        = C_SIG_NB;
  localparam int DEPTH    = C_FIFO_DEPTH;
  localparam int CW       = clog2_min1(N);
  localparam int DROP_MAX = (1 << C_DROP_WIDTH) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic [N-1:0]            rise_mask, fall_mask, sig;
  logic                    evt_ready, clr_overflow;
  logic [N-1:0]            evt_pulse;
  logic                    evt_valid, evt_rise, overflow;
  logic [CW-1:0]           evt_chan;
  logic [C_TS_WIDTH-1:0]   evt_tstamp;
  logic [C_FIFO_LVL_W-1:0] fifo_level;
  logic [C_DROP_WIDTH-1:0] drop_cnt;

  always #5 clk = ~clk;

  edge_event_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_rise_mask    (rise_mask),
    .i_fall_mask    (fall_mask),
    .i_sig          (sig),
    .o_evt_pulse    (evt_pulse),
    .o_evt_valid    (evt_valid),
    .i_evt_ready    (evt_ready),
    .o_evt_chan     (evt_chan),
    .o_evt_rise     (evt_rise),
    .o_evt_tstamp   (evt_tstamp),
    .o_fifo_level   (fifo_level),
    .o_overflow     (overflow),
    .o_drop_cnt     (drop_cnt),
    .i_clr_overflow (clr_overflow)
  );

  typedef struct {
    int                    chan;
    bit                    rise;
    logic [C_TS_WIDTH-1:0] ts;
  } rec_t;

  // Reference model state: a record queue, one pending slot per channel, counters.
  rec_t                  m_fifo[$];
  rec_t                  m_pend[N];
  bit   [N-1:0]          m_pend_v;
  bit   [N-1:0]          m_sig, m_pulse;
  bit                    m_started;
  logic [C_TS_WIDTH-1:0] m_ts;
  bit                    m_ovf;
  int                    m_cnt;

  rec_t obs_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_fifo.delete();
    m_pend_v  = '0;
    m_sig     = '0;
    m_pulse   = '0;
    m_started = 1'b0;
    m_ts      = '0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
  endfunction

  function automatic void model_clock();
    int     n;
    bit     pop;
    bit     [N-1:0] rise_e, fall_e, edges, held;
    int     winner;
    int     ndrop;
    int     base;
    n      = m_fifo.size();
    pop    = (n != 0) && evt_ready;
    held   = m_pend_v;
    rise_e = '0;
    fall_e = '0;
    winner = -1;
    ndrop  = 0;
    if (enable && m_started) begin
      rise_e = sig & ~m_sig & rise_mask;
      fall_e = ~sig & m_sig & fall_mask;
    end
    edges = rise_e | fall_e;
    for (int i = 0; i < N; i++) if (held[i] && winner < 0) winner = i;
    if (pop) m_fifo.delete(0);
    if (winner >= 0 && (n < DEPTH || pop)) begin
      m_fifo.push_back(m_pend[winner]);
      m_pend_v[winner] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (edges[i]) begin
        if (held[i]) ndrop++;
        else begin
          m_pend_v[i] = 1'b1;
          m_pend[i]   = '{i, rise_e[i], m_ts};
        end
      end
    end
    if (ndrop > 0) begin
      base  = clr_overflow ? 0 : m_cnt;
      m_ovf = 1'b1;
      m_cnt = (base + ndrop > DROP_MAX) ? DROP_MAX : base + ndrop;
    end else if (clr_overflow) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    m_pulse   = edges;
    m_sig     = sig;
    m_started = 1'b1;
    m_ts      = m_ts + 1;
  endfunction

  task automatic compare_all();
    rec_t h;
    h = '{0, 1'b0, '0};
    if (m_fifo.size() != 0) h = m_fifo[0];
    check("pulse",    64'(evt_pulse),  64'(m_pulse));
    check("valid",    64'(evt_valid),  64'(m_fifo.size() != 0));
    check("chan",     64'(evt_chan),   64'(h.chan));
    check("rise",     64'(evt_rise),   64'(h.rise));
    check("tstamp",   64'(evt_tstamp), 64'(h.ts));
    check("level",    64'(fifo_level), 64'(m_fifo.size()));
    check("overflow", 64'(overflow),   64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt),   64'(m_cnt));
  endtask

  // Called at a falling edge with inputs already set for the next rising edge.
  task automatic step();
    if (evt_valid && evt_ready) obs_q.push_back('{int'(evt_chan), evt_rise, evt_tstamp});
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step_until_ts(input logic [C_TS_WIDTH-1:0] target);
    for (int k = 0; k < 200 && m_ts != target; k++) step();
  endtask

  int ready_pct;

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    rise_mask    = '1;
    fall_mask    = '1;
    sig          = 5'b00001;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(evt_valid),  64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_pulse", 64'(evt_pulse),  64'd0);
    check("rst_ovf",   64'(overflow),   64'd0);
    check("rst_cnt",   64'(drop_cnt),   64'd0);
    rst_n = 1'b1;

    // First sample after reset raises nothing even though i_sig[0]=1.
    step();
    check("first_pulse", 64'(evt_pulse), 64'd0);
    check("first_valid", 64'(evt_valid), 64'd0);
    step_until_ts(10);
    sig[0] = 1'b0;
    step();
    check("t1_pulse", 64'(evt_pulse), 64'b00001);
    check("t1_valid_early", 64'(evt_valid), 64'd0);
    step();
    check("t1_pulse_off", 64'(evt_pulse), 64'd0);
    check("t1_valid", 64'(evt_valid), 64'd1);
    check("t1_chan", 64'(evt_chan), 64'd0);
    check("t1_rise", 64'(evt_rise), 64'd0);
    check("t1_ts", 64'(evt_tstamp), 64'd10);

    // Simultaneous edges drain lowest channel first on consecutive cycles.
    step_until_ts(20);
    sig = 5'b10101;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check("t2_valid", 64'(evt_valid), 64'd1);
      check("t2_chan", 64'(evt_chan), 64'(2 * k));
      check("t2_rise", 64'(evt_rise), 64'd1);
      check("t2_ts", 64'(evt_tstamp), 64'd20);
      step();
    end

    // Masking: only falling edges recorded.
    rise_mask = '0;
    fall_mask = '1;
    sig = '0;
    repeat (8) step();
    obs_q.delete();
    sig[3] = 1'b1;
    step();
    step();
    sig[3] = 1'b0;
    repeat (7) step();
    check("t3_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) begin
      check("t3_chan", 64'(obs_q[0].chan), 64'd3);
      check("t3_rise", 64'(obs_q[0].rise), 64'd0);
    end

    // Full FIFO: 16 stored, 17th pending, 18th dropped.
    rise_mask = '1;
    evt_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      sig[1] = ~sig[1];
      step();
      step();
    end
    check("t4_level", 64'(fifo_level), 64'd16);
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_cnt", 64'(drop_cnt), 64'd1);
    obs_q.delete();
    evt_ready = 1'b1;
    repeat (40) step();
    check("t4_drained", 64'(obs_q.size()), 64'd17);
    for (int i = 0; i < obs_q.size(); i++) begin
      check("t4_chan", 64'(obs_q[i].chan), 64'd1);
      check("t4_rise", 64'(obs_q[i].rise), 64'(i % 2 == 0));
      check("t4_ts_step", 64'(obs_q[i].ts - obs_q[0].ts), 64'(2 * i));
    end

    // Clear collides with a drop: drop wins and count restarts at 1.
    sig[2] = 1'b1;
    step();
    sig[2] = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t5_ovf", 64'(overflow), 64'd1);
    check("t5_cnt", 64'(drop_cnt), 64'd1);
    repeat (4) step();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t5_clr_ovf", 64'(overflow), 64'd0);
    check("t5_clr_cnt", 64'(drop_cnt), 64'd0);

    // Asynchronous reset mid-run with five records queued.
    evt_ready = 1'b0;
    sig = 5'b11111;
    repeat (8) step();
    check("t6_level", 64'(fifo_level), 64'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(evt_valid),  64'd0);
    check("t6_rst_level", 64'(fifo_level), 64'd0);
    check("t6_rst_pulse", 64'(evt_pulse),  64'd0);
    check("t6_rst_chan",  64'(evt_chan),   64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step_until_ts(3);
    sig = '0;
    step();
    step();
    check("t6_chan", 64'(evt_chan), 64'd0);
    check("t6_rise", 64'(evt_rise), 64'd0);
    check("t6_ts",   64'(evt_tstamp), 64'd3);

    // Randomized phase with varying back-pressure.
    ready_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(0, 3))
          0:       ready_pct = 0;
          1:       ready_pct = 50;
          default: ready_pct = 90;
        endcase
      end
      if (c % 64 == 0) begin
        rise_mask = N'($urandom);
        fall_mask = N'($urandom);
      end
      enable       = ($urandom_range(0, 9) != 0);
      evt_ready    = ($urandom_range(0, 99) < ready_pct);
      sig          = sig ^ N'($urandom & $urandom);
      clr_overflow = ($urandom_range(0, 999) == 0);
      step();
    end
    clr_overflow = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
